// File: rtl/attr_palette_fetch_pkg.sv
// Shared constants, stage bundle and address helper for the
// attribute-table palette fetch path.
package attr_pkg;

   localparam int ATTR_COLS         = 8;
   localparam int ATTR_ROWS         = 8;
   localparam int ATTR_BYTES_PER_NT = ATTR_COLS * ATTR_ROWS;

   localparam logic [7:0] MAX_ROW = 8'd239;

   localparam logic [1:0] Q_TL = 2'd0;
   localparam logic [1:0] Q_TR = 2'd1;
   localparam logic [1:0] Q_BL = 2'd2;
   localparam logic [1:0] Q_BR = 2'd3;

   typedef struct packed {
      logic       valid;
      logic [1:0] quad;
      logic       oob;
   } s1_t;

   // Byte index inside one 64-byte table: one byte per 32x32 block.
   function automatic logic [5:0] attr_idx(
      input logic [7:0] row,
      input logic [7:0] col
   );
      return {row[7:5], col[7:5]};
   endfunction

   function automatic logic [1:0] quad_of(
      input logic [7:0] row,
      input logic [7:0] col
   );
      return {row[4], col[4]};
   endfunction

endpackage

// File: rtl/attr_palette_fetch_if.sv
// Pixel request, ROM and palette result signals of the fetch stage.
// slave = the fetch block, master = raster side / ROM / consumer.
interface attr_palette_fetch_if #(
   parameter int ADDR_W = 7,
   parameter int CNT_W  = 16
);

   logic              in_valid;
   logic [7:0]        in_col;
   logic [7:0]        in_row;
   logic [ADDR_W-7:0] in_nt;
   logic              flush;
   logic [ADDR_W-1:0] rom_addr;
   logic              rom_en;
   logic [7:0]        rom_data;
   logic              out_valid;
   logic [1:0]        out_pal;
   logic              out_oob;
   logic [CNT_W-1:0]  miss_cnt;

   modport slave (
      input  in_valid,
      input  in_col,
      input  in_row,
      input  in_nt,
      input  flush,
      input  rom_data,
      output rom_addr,
      output rom_en,
      output out_valid,
      output out_pal,
      output out_oob,
      output miss_cnt
   );

   modport master (
      output in_valid,
      output in_col,
      output in_row,
      output in_nt,
      output flush,
      output rom_data,
      input  rom_addr,
      input  rom_en,
      input  out_valid,
      input  out_pal,
      input  out_oob,
      input  miss_cnt
   );

endinterface

// File: rtl/attr_palette_fetch_quad_sel.sv
// Picks the 2-bit palette select of one 16x16 quadrant
// out of an attribute byte.
module attr_quad_sel
   import attr_pkg::*;
(
   input  logic [7:0] attr,
   input  logic [1:0] quad,
   output logic [1:0] pal
);

   always_comb begin
      pal = 2'd0;
      unique case (quad)
         Q_TL: pal = attr[1:0];
         Q_TR: pal = attr[3:2];
         Q_BL: pal = attr[5:4];
         Q_BR: pal = attr[7:6];
      endcase
   end

endmodule

// File: rtl/attr_palette_fetch.sv
// Two-stage attribute fetch: address register, then byte select
// with a one-entry cache of the last fetched attribute byte.
module attr_palette_fetch
   import attr_pkg::*;
#(
   parameter int ADDR_W = 7,
   parameter int CNT_W  = 16
) (
   input logic                clk,
   input logic                rst_n,
   attr_palette_fetch_if.slave bus
);

   if (ADDR_W < 7) begin : g_bad_addr_w
      $error("attr_palette_fetch: ADDR_W must be >= 7");
   end

   s1_t               s1;
   logic [ADDR_W-1:0] addr_q;

   logic              cache_valid;
   logic [ADDR_W-1:0] cache_tag;
   logic [7:0]        cache_byte;
   logic [CNT_W-1:0]  cnt_q;

   logic              hit;
   logic              miss;
   logic [7:0]        sel_byte;
   logic [1:0]        pal_raw;

   logic              out_valid_q;
   logic [1:0]        out_pal_q;
   logic              out_oob_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1     <= '0;
         addr_q <= '0;
      end else begin
         s1.valid <= bus.in_valid;
         if (bus.in_valid) begin
            addr_q  <= {bus.in_nt, attr_idx(bus.in_row, bus.in_col)};
            s1.quad <= quad_of(bus.in_row, bus.in_col);
            s1.oob  <= (bus.in_row > MAX_ROW);
         end
      end
   end

   // Tag written at the previous edge is visible here,
   // so back-to-back same-block requests hit.
   always_comb begin
      hit      = cache_valid && (cache_tag == addr_q);
      sel_byte = hit ? cache_byte : bus.rom_data;
      miss     = s1.valid && !s1.oob && !hit;
   end

   attr_quad_sel u_quad_sel (
      .attr (sel_byte),
      .quad (s1.quad),
      .pal  (pal_raw)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_pal_q   <= 2'd0;
         out_oob_q   <= 1'b0;
      end else begin
         out_valid_q <= s1.valid;
         out_oob_q   <= s1.oob;
         out_pal_q   <= s1.oob ? 2'd0 : pal_raw;
      end
   end

   // Flush outranks a same-edge miss; the result itself
   // still comes straight from rom_data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cache_valid <= 1'b0;
         cache_tag   <= '0;
         cache_byte  <= 8'd0;
         cnt_q       <= '0;
      end else begin
         if (miss) begin
            cache_tag  <= addr_q;
            cache_byte <= bus.rom_data;
         end
         if (bus.flush) begin
            cache_valid <= 1'b0;
            cnt_q       <= '0;
         end else if (miss) begin
            cache_valid <= 1'b1;
            if (cnt_q != {CNT_W{1'b1}}) begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   assign bus.rom_addr  = addr_q;
   assign bus.rom_en    = miss;
   assign bus.out_valid = out_valid_q;
   assign bus.out_pal   = out_pal_q;
   assign bus.out_oob   = out_oob_q;
   assign bus.miss_cnt  = cnt_q;

endmodule

// File: tb/tb_attr_palette_fetch.sv
// Scoreboard bench for attr_palette_fetch with a small
// miss counter so saturation is reachable.
module tb_attr_palette_fetch;

   localparam int ADDR_W = 7;
   localparam int CNT_W  = 2;

   typedef struct {
      int pal;
      int oob;
      int cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_chk;
   int   n_pass;
   int   en_cnt;
   int   en0;
   exp_t sb[$];
   logic [7:0] mem [128];

   attr_palette_fetch_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

   attr_palette_fetch #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   assign bus.rom_data = mem[bus.rom_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.rom_en) en_cnt++;
      if (bus.out_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("out_pal", int'(bus.out_pal), e.pal);
            chk("out_oob", int'(bus.out_oob), e.oob);
            chk("out_cycle", cyc, e.cyc);
         end
      end
   end

   // Called at a negedge; returns at the next negedge.
   task automatic send(input int nt, input int col, input int row,
                       input int pal, input int oob);
      exp_t e;
      bus.in_valid = 1'b1;
      bus.in_nt    = nt[ADDR_W-7:0];
      bus.in_col   = col[7:0];
      bus.in_row   = row[7:0];
      e.pal = pal;
      e.oob = oob;
      e.cyc = cyc + 2;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic drain();
      int k;
      bus.in_valid = 1'b0;
      k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
      sb.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic do_flush();
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 8'(i * 37 + 5);
      mem[7'h08] = 8'h80;
      mem[7'h0F] = 8'h20;
      mem[7'h11] = 8'h12;
      mem[7'h00] = 8'hFC;
      mem[7'h40] = 8'hA8;

      n_chk = 0;
      n_pass = 0;
      en_cnt = 0;
      cyc = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_nt = '0;
      bus.in_col = 8'd16;
      bus.in_row = 8'd48;
      bus.flush = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_rom_addr", int'(bus.rom_addr), 0);
      chk("rst_rom_en", int'(bus.rom_en), 0);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_out_pal", int'(bus.out_pal), 0);
      chk("rst_out_oob", int'(bus.out_oob), 0);
      chk("rst_miss_cnt", int'(bus.miss_cnt), 0);
      bus.in_valid = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      send(0, 16, 48, 2, 0);
      chk("first_rom_addr", int'(bus.rom_addr), 8'h08);
      chk("first_rom_en", int'(bus.rom_en), 1);
      drain();
      chk("first_miss_cnt", int'(bus.miss_cnt), 1);

      do_flush();
      chk("flush_cnt", int'(bus.miss_cnt), 0);
      en0 = en_cnt;
      send(0, 224, 32, 0, 0);
      send(0, 240, 32, 0, 0);
      send(0, 224, 48, 2, 0);
      send(0, 240, 48, 0, 0);
      drain();
      chk("quad_miss_cnt", int'(bus.miss_cnt), 1);
      chk("quad_rom_en", en_cnt - en0, 1);

      do_flush();
      en0 = en_cnt;
      send(0, 32, 64, 2, 0);
      send(0, 0, 0, 0, 0);
      send(0, 32, 64, 2, 0);
      drain();
      chk("hm_miss_cnt", int'(bus.miss_cnt), 3);
      chk("hm_rom_en", en_cnt - en0, 3);

      do_flush();
      en0 = en_cnt;
      send(0, 32, 64, 2, 0);
      send(0, 0, 240, 0, 1);
      send(0, 32, 64, 2, 0);
      drain();
      chk("oob_miss_cnt", int'(bus.miss_cnt), 1);
      chk("oob_rom_en", en_cnt - en0, 1);

      send(0, 0, 0, 0, 0);
      drain();
      en0 = en_cnt;
      send(0, 32, 64, 2, 0);
      bus.in_valid = 1'b0;
      bus.flush = 1'b1;
      chk("coll_rom_en", int'(bus.rom_en), 1);
      @(negedge clk);
      bus.flush = 1'b0;
      drain();
      chk("coll_miss_cnt", int'(bus.miss_cnt), 0);
      send(0, 32, 64, 2, 0);
      drain();
      chk("coll_remiss_cnt", int'(bus.miss_cnt), 1);
      chk("coll_rom_en_total", en_cnt - en0, 2);

      send(1, 0, 0, 0, 0);
      chk("nt_rom_addr", int'(bus.rom_addr), 8'h40);
      chk("nt_rom_en", int'(bus.rom_en), 1);
      drain();
      chk("nt_miss_cnt", int'(bus.miss_cnt), 2);

      do_flush();
      en0 = en_cnt;
      send(0, 0, 0, 0, 0);
      send(0, 32, 64, 2, 0);
      send(0, 0, 0, 0, 0);
      send(0, 32, 64, 2, 0);
      drain();
      chk("sat_miss_cnt", int'(bus.miss_cnt), 3);
      chk("sat_rom_en", en_cnt - en0, 4);
      send(1, 0, 0, 0, 0);
      drain();
      chk("sat_hold_cnt", int'(bus.miss_cnt), 3);

      bus.in_valid = 1'b1;
      bus.in_nt = '0;
      bus.in_col = 8'd16;
      bus.in_row = 8'd48;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("midrst_out_valid", int'(bus.out_valid), 0);
      chk("midrst_miss_cnt", int'(bus.miss_cnt), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
